// File: rtl/shift_add_mult_pkg.sv
// shift_add_mult_pkg: shared multiplier/divider constants (2-bit FSM state encodings)
package shift_add_mult_pkg;
    localparam logic [1:0] S1 = 2'b00;
    localparam logic [1:0] S2 = 2'b01;
    localparam logic [1:0] S3 = 2'b10;
endpackage

// File: rtl/shift_add_mult_addern.sv
// addern: n-bit ripple-carry adder
//   carryin  in   1   carry into bit 0
//   X, Y     in   n   addends
//   S        out  n   sum
//   carryout out  1   carry out of bit n-1
module addern #(
    parameter int n = 16
) (
    input  logic         carryin,
    input  logic [n-1:0] X,
    input  logic [n-1:0] Y,
    output logic [n-1:0] S,
    output logic         carryout
);
    logic [n:0] c;
    assign c[0] = carryin;
    genvar i;
    for (i = 0; i < n; i++) begin : g_fa
        assign S[i]   = X[i] ^ Y[i] ^ c[i];
        assign c[i+1] = (X[i] & Y[i]) | (c[i] & (X[i] ^ Y[i]));
    end
    assign carryout = c[n];
endmodule

// File: rtl/shift_add_mult.sv
// shift_add_mult: sequential unsigned n x n -> 2n shift-and-add multiplier
//   Clock   in   1    rising-edge clock
//   Resetn  in   1    asynchronous active-low reset
//   Start   in   1    request, accepted only when idle
//   DataA   in   n    multiplicand
//   DataB   in   n    multiplier
//   P       out  2n   product (valid while Done=1)
//   Done    out  1    product valid
module shift_add_mult
    import shift_add_mult_pkg::*;
#(
    parameter int n = 8
) (
    input  logic           Clock,
    input  logic           Resetn,
    input  logic           Start,
    input  logic [n-1:0]   DataA,
    input  logic [n-1:0]   DataB,
    output logic [2*n-1:0] P,
    output logic           Done
);
    localparam int CW = $clog2(n);
    localparam logic [CW-1:0] LAST = CW'(n - 1);

    logic [1:0]     state, next;
    logic [2*n-1:0] A, sum;
    logic [n-1:0]   B;
    logic [CW-1:0]  count;

    // Adding zero when B[0]=0 equals holding P, and keeps carryout at 0 outside S2 too.
    addern #(.n(2 * n)) u_add (
        .carryin  (1'b0),
        .X        (P),
        .Y        (B[0] ? A : '0),
        .S        (sum),
        .carryout ()
    );

    always_ff @(posedge Clock or negedge Resetn)
        if (!Resetn) state <= S1;
        else         state <= next;

    // S3 exits only once Done is already high, so Done is seen for at least one cycle.
    always_comb
        next = (state == S1) ? (Start ? S2 : S1) :
               (state == S2) ? ((count == '0) ? S3 : S2) :
               (state == S3) ? ((Done && !Start) ? S1 : S3) : S1;

    always_ff @(posedge Clock or negedge Resetn)
        if (!Resetn) begin
            A     <= '0;
            B     <= '0;
            count <= '0;
            P     <= '0;
            Done  <= 1'b0;
        end else begin
            Done <= (state == S3) && !(Done && !Start);
            if (state == S1 && Start) begin
                A     <= {{n{1'b0}}, DataA};
                B     <= DataB;
                P     <= '0;
                count <= LAST;
            end else if (state == S2) begin
                P <= sum;
                A <= A << 1;
                B <= B >> 1;
                if (count != '0) count <= count - 1'b1;
            end
        end
endmodule
